fft_8_reorder: RTL and testbench
================================

Name: fft_8_reorder

Overview:
- Sits directly downstream of fft_8 and consumes its framed output stream (out_real8/out_img8 with start/end strobes).
- The FFT delivers each N-point frame in bit-reversed index order. This block rewrites each frame into natural order (X[0]..X[N-1]) for later stages.
- Uses a ping-pong two-bank buffer, so back-to-back frames stream with no gap.

Parameters:
- LAYER, 3, log2 of frame length; N = 2^LAYER (8 for fft_8). LAYER >= 1.
- DW, 32, width of each real/imag component.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_start  in  1  high on first sample of an input frame.
- in_end  in  1  high on last sample of an input frame.
- in_real  in  DW  input real part (from fft_8 out_real8).
- in_img  in  DW  input imaginary part (from fft_8 out_img8).
- out_valid  out  1  output sample valid.
- out_start  out  1  high with output index 0.
- out_end  out  1  high with output index N-1.
- out_real  out  DW  reordered real part.
- out_img  out  DW  reordered imaginary part.
- err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst=1 at a clock edge): all outputs 0; write counter 0; write active cleared; write bank 0; read idle.
  - Buffer contents are not cleared.
  - Reset mid-frame or mid-read aborts both sides; no partial output follows.
- Input framing:
  - A frame is N consecutive cycles, from the in_start cycle to the in_end cycle, one sample per cycle, no gaps.
  - Samples outside an active frame are ignored.
- Write side:
  - State IDLE/WRITE.
  - in_start in any state writes the sample to index 0 of the write bank, sets wcnt=1, enters WRITE.
  - In WRITE, each cycle writes to bank[wcnt] and increments wcnt.
  - When the sample at index N-1 is written with in_end=1, the frame completes:
    - the bank is handed to the read side;
    - the write bank toggles;
    - state returns to IDLE.
- Framing errors (err pulses for one cycle on the offending cycle; the frame is dropped, never handed to the read side):
  - in_start while in WRITE: partial frame discarded and restarted at index 0 with the current sample.
  - in_end at index != N-1: state goes to IDLE.
  - Index N-1 written without in_end: state goes to IDLE.
  - in_start and in_end in the same cycle: treated as in_end at index 0, i.e. an error.
- Read side:
  - Starts on the cycle after frame completion and runs N cycles, rcnt = 0..N-1.
  - Read address = bit-reverse of rcnt over LAYER bits.
  - Registered read: output sample k appears one cycle after its read cycle.
  - Latency: out_start is high exactly 2 cycles after the in_end cycle.
  - out_valid stays high for N consecutive cycles; out_end is on the last of them.
- Back-to-back frames:
  - A new frame may begin the cycle after in_end. It writes the other bank while the previous bank is read.
  - Reading of frame f always finishes before frame f+1 completes, so consecutive output frames are also gapless (out_end of f directly followed by out_start of f+1).
  - No overflow is possible under legal framing.
- Output when out_valid=0: out_real/out_img hold 0; out_start/out_end are 0.
- Data is passed bit-exact; no arithmetic is performed.

Test Plan:
- Single frame (LAYER=3): in_start at cycle t, in_real = 0..7 and in_img = 100..107 over t..t+7, in_end at t+7 -> out_start at t+9; out_real sequence 0,4,2,6,1,5,3,7 and out_img sequence 100,104,102,106,101,105,103,107; out_end at t+16; err never high.
- Three back-to-back frames with distinct values (frame f uses values 10f+i) -> 24 contiguous out_valid cycles, each frame reordered correctly, out_start at t+9, t+17, t+25.
- in_start again at index 4 of a frame, then a full 8-sample frame -> err pulse at the restart cycle; exactly one output frame, containing the second frame's data.
- in_end at index 5 -> err pulse that cycle, no output; a following legal frame is output normally and uses the correct bank.
- rst asserted during output sample 3 -> next cycle all outputs 0; no remaining samples emitted; a new frame after reset is output with 2-cycle latency.
- LAYER=2 parameter run with values 0..3 -> output order 0,2,1,3.

Source files
------------

// File: rtl/fft_8_reorder.sv
// Rewrites bit-reversed FFT frames into natural order via a ping-pong two-bank buffer.
// Latency: out_start is high 2 cycles after the in_end cycle; output frames are N cycles, gapless back-to-back.
// No backpressure: input is accepted every cycle, framing errors pulse err and drop the frame.
module fft_8_reorder #(
  parameter int LAYER = 3,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_start,
  input  logic          in_end,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_img,
  output logic          out_valid,
  output logic          out_start,
  output logic          out_end,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_img,
  output logic          err
);

  localparam int N = 1 << LAYER;
  localparam logic [LAYER-1:0] LAST = LAYER'(N - 1);

  typedef enum logic {W_IDLE, W_WRITE} wstate_t;

  // Two banks of N samples; the top address bit selects the bank.
  logic [DW-1:0] mem_real [0:2*N-1];
  logic [DW-1:0] mem_img  [0:2*N-1];

  wstate_t          wstate_q, wstate_d;
  logic [LAYER-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic             rd_active_q, rd_active_d;
  logic [LAYER-1:0] rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;
  logic             out_valid_q, out_valid_d;
  logic             out_start_q, out_start_d;
  logic             out_end_q, out_end_d;
  logic [DW-1:0]    out_real_q, out_real_d;
  logic [DW-1:0]    out_img_q, out_img_d;

  logic             we;
  logic [LAYER-1:0] widx;
  logic             frame_done;
  logic             err_d;
  logic [LAYER:0]   raddr;

  function automatic logic [LAYER-1:0] bitrev(input logic [LAYER-1:0] v);
    logic [LAYER-1:0] r;
    for (int b = 0; b < LAYER; b++) r[b] = v[LAYER-1-b];
    return r;
  endfunction

  // Write side: track frame position, detect framing errors, hand off completed banks.
  always_comb begin
    wstate_d   = wstate_q;
    wcnt_d     = wcnt_q;
    wbank_d    = wbank_q;
    we         = 1'b0;
    widx       = '0;
    frame_done = 1'b0;
    err_d      = 1'b0;
    if (in_start) begin
      // A start always (re)opens a frame at index 0; start+end together is an end at index 0.
      we = 1'b1;
      if (in_end) begin
        err_d    = 1'b1;
        wstate_d = W_IDLE;
      end else begin
        err_d    = (wstate_q == W_WRITE);
        wstate_d = W_WRITE;
        wcnt_d   = LAYER'(1);
      end
    end else if (wstate_q == W_WRITE) begin
      we   = 1'b1;
      widx = wcnt_q;
      if (wcnt_q == LAST) begin
        wstate_d = W_IDLE;
        if (in_end) begin
          frame_done = 1'b1;
          wbank_d    = ~wbank_q;
        end else begin
          err_d = 1'b1;
        end
      end else if (in_end) begin
        err_d    = 1'b1;
        wstate_d = W_IDLE;
      end else begin
        wcnt_d = wcnt_q + LAYER'(1);
      end
    end
  end

  // Read side: sweep the completed bank in bit-reversed address order into registered outputs.
  always_comb begin
    rd_active_d = rd_active_q;
    rcnt_d      = rcnt_q;
    rbank_d     = rbank_q;
    raddr       = {rbank_q, bitrev(rcnt_q)};
    out_valid_d = rd_active_q;
    out_start_d = rd_active_q && (rcnt_q == '0);
    out_end_d   = rd_active_q && (rcnt_q == LAST);
    out_real_d  = rd_active_q ? mem_real[raddr] : '0;
    out_img_d   = rd_active_q ? mem_img[raddr]  : '0;
    if (rd_active_q) begin
      rcnt_d = rcnt_q + LAYER'(1);
      if (rcnt_q == LAST) rd_active_d = 1'b0;
    end
    // A completion can coincide with the last read of the previous frame; the new frame wins.
    if (frame_done) begin
      rd_active_d = 1'b1;
      rcnt_d      = '0;
      rbank_d     = wbank_q;
    end
  end

  // Sample buffer: written in place, never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_real[{wbank_q, widx}] <= in_real;
      mem_img[{wbank_q, widx}]  <= in_img;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q    <= W_IDLE;
      wcnt_q      <= '0;
      wbank_q     <= 1'b0;
      rd_active_q <= 1'b0;
      rcnt_q      <= '0;
      rbank_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_end_q   <= 1'b0;
      out_real_q  <= '0;
      out_img_q   <= '0;
    end else begin
      wstate_q    <= wstate_d;
      wcnt_q      <= wcnt_d;
      wbank_q     <= wbank_d;
      rd_active_q <= rd_active_d;
      rcnt_q      <= rcnt_d;
      rbank_q     <= rbank_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_end_q   <= out_end_d;
      out_real_q  <= out_real_d;
      out_img_q   <= out_img_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_end   = out_end_q;
  assign out_real  = out_real_q;
  assign out_img   = out_img_q;
  // err flags the offending input cycle itself, so it is not registered.
  assign err       = err_d & ~rst;

endmodule

// File: tb/tb_fft_8_reorder.sv
// Directed bench for fft_8_reorder: LAYER=3 instance for framing/reorder cases, LAYER=2 instance for order check.
// Latency: expected output cycles are derived from the input cycle numbers (start at in_end + 2).
// Inputs driven #1 after posedge, outputs recorded on negedge.
module tb_fft_8_reorder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_start, in_end;
  logic [31:0] in_real, in_img;
  logic        out_valid, out_start, out_end, err;
  logic [31:0] out_real, out_img;

  logic        s2, e2;
  logic [31:0] r2, i2;
  logic        v2, os2, oe2, err2;
  logic [31:0] or2, oi2;

  always #5 clk = ~clk;

  fft_8_reorder #(.LAYER(3), .DW(32)) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_end(in_end),
    .in_real(in_real), .in_img(in_img), .out_valid(out_valid),
    .out_start(out_start), .out_end(out_end), .out_real(out_real),
    .out_img(out_img), .err(err)
  );

  fft_8_reorder #(.LAYER(2), .DW(32)) dut2 (
    .clk(clk), .rst(rst), .in_start(s2), .in_end(e2),
    .in_real(r2), .in_img(i2), .out_valid(v2),
    .out_start(os2), .out_end(oe2), .out_real(or2),
    .out_img(oi2), .err(err2)
  );

  typedef struct {
    int          cyc;
    logic        st;
    logic        en;
    logic [31:0] re;
    logic [31:0] im;
  } obs_t;

  obs_t obs[$];
  obs_t obs2[$];
  int   err_cyc[$];
  int   idle_bad = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int order3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int order2 [4] = '{0, 2, 1, 3};

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid output beat, error pulses, and any non-zero idle output.
  always @(negedge clk) begin
    if (out_valid === 1'b1)
      obs.push_back('{cyc: cyc, st: out_start, en: out_end, re: out_real, im: out_img});
    else if (out_start !== 1'b0 || out_end !== 1'b0 || out_real !== 32'd0 || out_img !== 32'd0)
      idle_bad++;
    if (err === 1'b1) err_cyc.push_back(cyc);
    if (err2 === 1'b1) err_cyc.push_back(cyc);
    if (v2 === 1'b1)
      obs2.push_back('{cyc: cyc, st: os2, en: oe2, re: or2, im: oi2});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic e, input logic [31:0] r, input logic [31:0] im);
    @(posedge clk);
    #1;
    in_start = s;
    in_end   = e;
    in_real  = r;
    in_img   = im;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Drives one legal 8-sample frame (real = rb+i, imag = ib+i); returns the in_start cycle.
  task automatic send_frame(input int rb, input int ib, output int t);
    for (int k = 0; k < 8; k++) begin
      drive(k == 0, k == 7, 32'(rb + k), 32'(ib + k));
      if (k == 0) t = cyc;
    end
  endtask

  // Compares recorded beats obs[off..off+7] against a natural-order frame starting at cycle c0.
  task automatic check_frame(input string tag, input int off, input int c0, input int rb, input int ib);
    for (int k = 0; k < 8; k++) begin
      if (off + k < obs.size()) begin
        check($sformatf("%s[%0d].cyc", tag, k), 64'(obs[off+k].cyc), 64'(c0 + k));
        check($sformatf("%s[%0d].start", tag, k), 64'(obs[off+k].st), 64'(k == 0));
        check($sformatf("%s[%0d].end", tag, k), 64'(obs[off+k].en), 64'(k == 7));
        check($sformatf("%s[%0d].real", tag, k), 64'(obs[off+k].re), 64'(rb + order3[k]));
        check($sformatf("%s[%0d].img", tag, k), 64'(obs[off+k].im), 64'(ib + order3[k]));
      end
    end
  endtask

  task automatic clear_obs();
    obs.delete();
    obs2.delete();
    err_cyc.delete();
  endtask

  initial begin
    int t, t2;
    rst = 1'b1;
    in_start = 1'b0; in_end = 1'b0; in_real = '0; in_img = '0;
    s2 = 1'b0; e2 = 1'b0; r2 = '0; i2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_start", 64'(out_start), 64'd0);
    check("rst.out_end", 64'(out_end), 64'd0);
    check("rst.out_real", 64'(out_real), 64'd0);
    check("rst.out_img", 64'(out_img), 64'd0);
    check("rst.err", 64'(err), 64'd0);
    check("rst.dut2_valid", 64'(v2), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    clear_obs();
    idle_bad = 0;

    // Single frame: real 0..7, imag 100..107.
    send_frame(0, 100, t);
    idle(10);
    check("single.count", 64'(obs.size()), 64'd8);
    check_frame("single", 0, t + 9, 0, 100);
    check("single.err", 64'(err_cyc.size()), 64'd0);
    clear_obs();

    // Three back-to-back frames: frame f uses 10f+i (imag offset by 500).
    send_frame(0, 500, t);
    send_frame(10, 510, t2);
    send_frame(20, 520, t2);
    idle(26);
    check("b2b.count", 64'(obs.size()), 64'd24);
    check_frame("b2b.f0", 0, t + 9, 0, 500);
    check_frame("b2b.f1", 8, t + 17, 10, 510);
    check_frame("b2b.f2", 16, t + 25, 20, 520);
    check("b2b.err", 64'(err_cyc.size()), 64'd0);
    clear_obs();

    // Restart: in_start at index 4, which begins a full frame of 20..27.
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, 1'b0, 32'(90 + k), 32'(190 + k));
      if (k == 0) t = cyc;
    end
    send_frame(20, 220, t2);
    idle(12);
    check("restart.err_count", 64'(err_cyc.size()), 64'd1);
    if (err_cyc.size() > 0) check("restart.err_cyc", 64'(err_cyc[0]), 64'(t + 4));
    check("restart.t2", 64'(t2), 64'(t + 4));
    check("restart.count", 64'(obs.size()), 64'd8);
    check_frame("restart", 0, t2 + 9, 20, 220);
    clear_obs();

    // Early in_end at index 5: dropped, next legal frame still correct.
    for (int k = 0; k < 6; k++) begin
      drive(k == 0, k == 5, 32'(70 + k), 32'(170 + k));
      if (k == 0) t = cyc;
    end
    idle(3);
    send_frame(40, 340, t2);
    idle(12);
    check("early_end.err_count", 64'(err_cyc.size()), 64'd1);
    if (err_cyc.size() > 0) check("early_end.err_cyc", 64'(err_cyc[0]), 64'(t + 5));
    check("early_end.count", 64'(obs.size()), 64'd8);
    check_frame("early_end", 0, t2 + 9, 40, 340);
    clear_obs();

    // Missing in_end on index 7: dropped with err on that cycle.
    for (int k = 0; k < 8; k++) begin
      drive(k == 0, 1'b0, 32'(80 + k), 32'(180 + k));
      if (k == 0) t = cyc;
    end
    idle(12);
    check("no_end.err_count", 64'(err_cyc.size()), 64'd1);
    if (err_cyc.size() > 0) check("no_end.err_cyc", 64'(err_cyc[0]), 64'(t + 7));
    check("no_end.count", 64'(obs.size()), 64'd0);
    clear_obs();

    // Reset during output sample 3: only samples 0..3 appear.
    send_frame(50, 550, t);
    idle(4);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid.valid_after", 64'(out_valid), 64'd0);
    check("rst_mid.real_after", 64'(out_real), 64'd0);
    idle(12);
    check("rst_mid.count", 64'(obs.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < obs.size()) begin
        check($sformatf("rst_mid[%0d].cyc", k), 64'(obs[k].cyc), 64'(t + 9 + k));
        check($sformatf("rst_mid[%0d].real", k), 64'(obs[k].re), 64'(50 + order3[k]));
      end
    end
    clear_obs();
    send_frame(60, 660, t);
    idle(10);
    check("post_rst.count", 64'(obs.size()), 64'd8);
    check_frame("post_rst", 0, t + 9, 60, 660);
    clear_obs();

    // LAYER=2 instance: values 0..3 come out as 0,2,1,3, start 2 cycles after in_end.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      s2 = (k == 0); e2 = (k == 3); r2 = 32'(k); i2 = 32'(30 + k);
      if (k == 0) t = cyc;
    end
    @(posedge clk);
    #1;
    s2 = 1'b0; e2 = 1'b0; r2 = '0; i2 = '0;
    idle(8);
    check("l2.count", 64'(obs2.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < obs2.size()) begin
        check($sformatf("l2[%0d].cyc", k), 64'(obs2[k].cyc), 64'(t + 5 + k));
        check($sformatf("l2[%0d].start", k), 64'(obs2[k].st), 64'(k == 0));
        check($sformatf("l2[%0d].end", k), 64'(obs2[k].en), 64'(k == 3));
        check($sformatf("l2[%0d].real", k), 64'(obs2[k].re), 64'(order2[k]));
        check($sformatf("l2[%0d].img", k), 64'(obs2[k].im), 64'(30 + order2[k]));
      end
    end
    check("l2.err", 64'(err_cyc.size()), 64'd0);

    check("idle_outputs_zero", 64'(idle_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
